// File: rtl/ammrv_pkg.sv
// Shared definitions for the Avalon-MM pipelined register responder.
// Holds bus widths, the responder state encoding and the byte-lane
// merge helper used on writes.
package ammrv_pkg;

  localparam int AMM_AW  = 32;
  localparam int AMM_DW  = 32;
  localparam int AMM_BEW = AMM_DW / 8;

  // Responder handshake states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCEPT = 2'd2;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [AMM_DW-1:0] be_merge(
    input logic [AMM_DW-1:0]  old_data,
    input logic [AMM_DW-1:0]  wdata,
    input logic [AMM_BEW-1:0] be
  );
    logic [AMM_DW-1:0] res;
    res = old_data;
    for (int b = 0; b < AMM_BEW; b++) begin
      if (be[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ammrv_pipelined_regs_if.sv
// Avalon-MM pipelined bus bundle with readdatavalid.
// master: drives address/byteenable/writedata/read/write,
//         observes waitrequest/readdata/readdatavalid.
// slave : the responder side (opposite directions).
interface ammrv_pipelined_regs_if;
  import ammrv_pkg::*;

  logic [AMM_AW-1:0]  s_address;
  logic [AMM_BEW-1:0] s_byteenable;
  logic [AMM_DW-1:0]  s_writedata;
  logic               s_read;
  logic               s_write;
  logic               s_waitrequest;
  logic [AMM_DW-1:0]  s_readdata;
  logic               s_readdatavalid;

  modport master (
    output s_address, s_byteenable, s_writedata, s_read, s_write,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport slave (
    input  s_address, s_byteenable, s_writedata, s_read, s_write,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/ammrv_rdpipe.sv
// Fixed-latency read response pipeline.
// Ports: clk, reset_n (async active-low clear), in_valid/in_data (read
// captured at the accept edge), out_valid/out_data (registered response,
// data forced to zero when not valid). Depth = P_DEPTH cycles.
module ammrv_rdpipe
  import ammrv_pkg::*;
#(
  parameter int P_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [AMM_DW-1:0] in_data,
  output logic              out_valid,
  output logic [AMM_DW-1:0] out_data
);

  logic [P_DEPTH-1:0] valid_sr;
  logic [AMM_DW-1:0]  data_sr [P_DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its neighbour, giving a true shift.
  // NOTE: the data stages are reset too: a response slot must read back
  // zero after reset, and in-flight reads must vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_sr <= '0;
      for (int i = 0; i < P_DEPTH; i++) data_sr[i] <= '0;
    end else begin
      valid_sr[0] <= in_valid;
      data_sr[0]  <= in_valid ? in_data : '0;
      for (int i = 1; i < P_DEPTH; i++) begin
        valid_sr[i] <= valid_sr[i-1];
        data_sr[i]  <= data_sr[i-1];
      end
    end
  end

  assign out_valid = valid_sr[P_DEPTH-1];
  assign out_data  = data_sr[P_DEPTH-1];

endmodule

// File: rtl/ammrv_pipelined_regs.sv
// Avalon-MM pipelined responder backed by a byte-enabled register file.
// Ports: clk, reset_n (async active-low), s (slave side of the bus),
// hold (external stall, forces waitrequest high), regs_q (flat register
// contents, reg i at [32i+31:32i]).
// Commands wait P_WAITSTATES cycles before acceptance; reads respond
// P_RDLATENCY cycles after the accept edge.
module ammrv_pipelined_regs
  import ammrv_pkg::*;
#(
  parameter int          P_NREGS_LOG2  = 4,
  parameter int          P_WAITSTATES  = 1,
  parameter int          P_RDLATENCY   = 2,
  parameter logic [31:0] P_RESET_VALUE = 32'h0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  ammrv_pipelined_regs_if.slave               s,
  input  logic                                hold,
  output logic [AMM_DW*(2**P_NREGS_LOG2)-1:0] regs_q
);

  localparam int         NREGS = 2 ** P_NREGS_LOG2;
  localparam logic [2:0] WS    = 3'(P_WAITSTATES);

  logic [2:0]              wcnt;
  logic [1:0]              state;
  logic                    cmd;
  logic                    accept;
  logic                    wr_accept;
  logic                    rd_accept;
  logic [P_NREGS_LOG2-1:0] index;
  logic [AMM_DW-1:0]       regs [NREGS];
  logic                    unused_addr_bits;

  // Only the word index is decoded; the rest of the address aliases.
  assign index            = s.s_address[P_NREGS_LOG2+1:2];
  assign unused_addr_bits = ^{s.s_address[AMM_AW-1:P_NREGS_LOG2+2], s.s_address[1:0]};

  assign cmd       = s.s_read | s.s_write;
  assign accept    = cmd & ~hold & (wcnt == WS);
  // Read+write together is treated as a write only.
  assign wr_accept = accept & s.s_write;
  assign rd_accept = accept & s.s_read & ~s.s_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    wcnt <= '0;
    else if (!cmd)   wcnt <= '0;
    else if (hold)   wcnt <= wcnt;
    else if (accept) wcnt <= '0;
    else             wcnt <= wcnt + 3'd1;
  end

  // NOTE: state gets a default before the conditions so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state = ST_IDLE;
    if (accept)                   state = ST_ACCEPT;
    else if (cmd || wcnt != '0)   state = ST_WAIT;
  end

  assign s.s_waitrequest = (state != ST_ACCEPT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= P_RESET_VALUE;
    end else if (wr_accept) begin
      regs[index] <= be_merge(regs[index], s.s_writedata, s.s_byteenable);
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_q[AMM_DW*g +: AMM_DW] = regs[g];
  end

  // Data is sampled from the pre-edge register contents, so a later write
  // cannot disturb a response already in flight.
  ammrv_rdpipe #(
    .P_DEPTH (P_RDLATENCY)
  ) u_rdpipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (rd_accept),
    .in_data   (regs[index]),
    .out_valid (s.s_readdatavalid),
    .out_data  (s.s_readdata)
  );

endmodule

// File: tb/tb_ammrv_pipelined_regs.sv
// Directed bench for ammrv_pipelined_regs. Three instances cover the
// parameter sets needed: a (WS=1, LAT=2), b (WS=0, LAT=2), c (WS=0, LAT=3).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ammrv_pipelined_regs;
  import ammrv_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         hold_a, hold_b, hold_c;
  logic [511:0] rq_a, rq_b, rq_c;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] t5_addr [6];
  logic        t5_rd   [6];
  logic        t5_wr   [6];
  logic [31:0] t5_exp  [6];

  ammrv_pipelined_regs_if ia ();
  ammrv_pipelined_regs_if ib ();
  ammrv_pipelined_regs_if ic ();

  ammrv_pipelined_regs #(.P_NREGS_LOG2(4), .P_WAITSTATES(1), .P_RDLATENCY(2), .P_RESET_VALUE(32'h0))
    dut_a (.clk(clk), .reset_n(reset_n), .s(ia), .hold(hold_a), .regs_q(rq_a));
  ammrv_pipelined_regs #(.P_NREGS_LOG2(4), .P_WAITSTATES(0), .P_RDLATENCY(2), .P_RESET_VALUE(32'h0))
    dut_b (.clk(clk), .reset_n(reset_n), .s(ib), .hold(hold_b), .regs_q(rq_b));
  ammrv_pipelined_regs #(.P_NREGS_LOG2(4), .P_WAITSTATES(0), .P_RDLATENCY(3), .P_RESET_VALUE(32'h0))
    dut_c (.clk(clk), .reset_n(reset_n), .s(ic), .hold(hold_c), .regs_q(rq_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_of(input logic [511:0] q, input int i);
    return q[32*i +: 32];
  endfunction

  task automatic idle_all();
    ia.s_read = 1'b0; ia.s_write = 1'b0; ia.s_address = '0; ia.s_byteenable = '0; ia.s_writedata = '0;
    ib.s_read = 1'b0; ib.s_write = 1'b0; ib.s_address = '0; ib.s_byteenable = '0; ib.s_writedata = '0;
    ic.s_read = 1'b0; ic.s_write = 1'b0; ic.s_address = '0; ic.s_byteenable = '0; ic.s_writedata = '0;
    hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
  endtask

  // Issue one command on instance a and count waitrequest-high cycles.
  task automatic a_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] be, output int waits);
    @(negedge clk);
    ia.s_read = rd; ia.s_write = wr; ia.s_address = addr;
    ia.s_writedata = data; ia.s_byteenable = be;
    waits = 0;
    #1;
    while (ia.s_waitrequest && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    @(negedge clk);
    ia.s_read = 1'b0; ia.s_write = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   w;
    logic [7:0] hold_t, rd_t, wr_t, rdv_t;

    // ---- 1: reset with random inputs ----
    idle_all();
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ia.s_read = 1'($urandom); ia.s_write = 1'($urandom); ia.s_address = $urandom;
      ia.s_writedata = $urandom; ia.s_byteenable = 4'($urandom); hold_a = 1'($urandom);
      ib.s_read = 1'($urandom); ib.s_write = 1'($urandom); ib.s_address = $urandom;
      ib.s_writedata = $urandom; ib.s_byteenable = 4'($urandom); hold_b = 1'($urandom);
      ic.s_read = 1'($urandom); ic.s_write = 1'($urandom); ic.s_address = $urandom;
      ic.s_writedata = $urandom; ic.s_byteenable = 4'($urandom); hold_c = 1'($urandom);
      #1;
      check($sformatf("rst_rdv_a%0d", c), 32'(ia.s_readdatavalid), 32'd0);
      check($sformatf("rst_rdata_a%0d", c), ia.s_readdata, 32'd0);
      check($sformatf("rst_rdv_c%0d", c), 32'(ic.s_readdatavalid), 32'd0);
    end
    for (int i = 0; i < 16; i++) check($sformatf("rst_reg_a%0d", i), reg_of(rq_a, i), 32'h0);
    check("rst_reg_b5", reg_of(rq_b, 5), 32'h0);
    check("rst_reg_c15", reg_of(rq_c, 15), 32'h0);
    @(negedge clk);
    idle_all();
    reset_n = 1'b1;
    #1;
    check("idle_wr_a", 32'(ia.s_waitrequest), 32'd1);
    check("idle_wr_b", 32'(ib.s_waitrequest), 32'd1);
    check("idle_rdv_b", 32'(ib.s_readdatavalid), 32'd0);

    // ---- 2: WS=1 writes with byte enables ----
    a_xfer(1'b0, 1'b1, 32'h8, 32'h1234_5678, 4'hF, w);
    check("t2_waits1", 32'(w), 32'd1);
    check("t2_reg2_full", reg_of(rq_a, 2), 32'h1234_5678);
    a_xfer(1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0100, w);
    check("t2_waits2", 32'(w), 32'd1);
    check("t2_reg2_lane2", reg_of(rq_a, 2), 32'h12BB_5678);
    a_xfer(1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 4'b0000, w);
    check("t2_waits_be0", 32'(w), 32'd1);
    check("t2_reg2_be0", reg_of(rq_a, 2), 32'h12BB_5678);

    // ---- 4: hold during a pending read, WS=1 ----
    a_xfer(1'b0, 1'b1, 32'h14, 32'hCAFE_0005, 4'hF, w);
    check("t4_preload", reg_of(rq_a, 5), 32'hCAFE_0005);
    hold_t = 8'b0000_1110;
    rd_t   = 8'b0001_1111;
    wr_t   = 8'b1110_1111;
    rdv_t  = 8'b0100_0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ia.s_read = rd_t[i]; ia.s_address = 32'h14; hold_a = hold_t[i];
      #1;
      check($sformatf("t4_wr%0d", i), 32'(ia.s_waitrequest), 32'(wr_t[i]));
      check($sformatf("t4_rdv%0d", i), 32'(ia.s_readdatavalid), 32'(rdv_t[i]));
      check($sformatf("t4_rdata%0d", i), ia.s_readdata, rdv_t[i] ? 32'hCAFE_0005 : 32'h0);
    end

    // ---- 3: WS=0 back-to-back, latency 2 ----
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ib.s_write = 1'b1; ib.s_address = 32'(i * 4);
      ib.s_writedata = 32'((i + 1) * 32'h11); ib.s_byteenable = 4'hF;
      #1;
      check($sformatf("t3_wwr%0d", i), 32'(ib.s_waitrequest), 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ib.s_write = 1'b0;
      ib.s_read = (i < 3);
      ib.s_address = (i < 3) ? 32'(i * 4) : 32'h0;
      #1;
      check($sformatf("t3_wr%0d", i), 32'(ib.s_waitrequest), (i < 3) ? 32'd0 : 32'd1);
      check($sformatf("t3_rdv%0d", i), 32'(ib.s_readdatavalid), (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
      check($sformatf("t3_rdata%0d", i), ib.s_readdata,
            (i >= 2 && i <= 4) ? 32'((i - 1) * 32'h11) : 32'h0);
    end

    // ---- 5: read / write / aliased read ordering, WS=0 ----
    @(negedge clk);
    ib.s_write = 1'b1; ib.s_address = 32'h4; ib.s_writedata = 32'hA5; ib.s_byteenable = 4'hF;
    #1;
    check("t5_preload_wr", 32'(ib.s_waitrequest), 32'd0);
    t5_rd   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    t5_wr   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    t5_addr = '{32'h4, 32'h4, 32'h44, 32'h0, 32'h0, 32'h0};
    t5_exp  = '{32'h0, 32'h0, 32'hA5, 32'h0, 32'h5A, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ib.s_read = t5_rd[i]; ib.s_write = t5_wr[i]; ib.s_address = t5_addr[i];
      ib.s_writedata = 32'h5A;
      #1;
      check($sformatf("t5_rdv%0d", i), 32'(ib.s_readdatavalid), (t5_exp[i] != 32'h0) ? 32'd1 : 32'd0);
      check($sformatf("t5_rdata%0d", i), ib.s_readdata, t5_exp[i]);
    end
    check("t5_reg1", reg_of(rq_b, 1), 32'h5A);

    // Read+write together behaves as a write with no response.
    @(negedge clk);
    ib.s_read = 1'b1; ib.s_write = 1'b1; ib.s_address = 32'hC;
    ib.s_writedata = 32'h77; ib.s_byteenable = 4'hF;
    #1;
    check("rw_wr", 32'(ib.s_waitrequest), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ib.s_read = 1'b0; ib.s_write = 1'b0;
      #1;
      check($sformatf("rw_rdv%0d", i), 32'(ib.s_readdatavalid), 32'd0);
    end
    check("rw_reg3", reg_of(rq_b, 3), 32'h77);

    // ---- 6: reset discards in-flight reads, latency 3 ----
    @(negedge clk);
    ic.s_write = 1'b1; ic.s_address = 32'h0; ic.s_writedata = 32'h99; ic.s_byteenable = 4'hF;
    #1;
    check("t6_preload_wr", 32'(ic.s_waitrequest), 32'd0);
    @(negedge clk);
    ic.s_write = 1'b0; ic.s_read = 1'b1; ic.s_address = 32'h0;
    #1;
    check("t6_rd0_wr", 32'(ic.s_waitrequest), 32'd0);
    @(negedge clk);
    ic.s_address = 32'h4;
    #1;
    check("t6_rd1_wr", 32'(ic.s_waitrequest), 32'd0);
    check("t6_reg0_pre", reg_of(rq_c, 0), 32'h99);
    @(negedge clk);
    ic.s_read = 1'b0;
    reset_n = 1'b0;
    #1;
    check("t6_rdv_rst", 32'(ic.s_readdatavalid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t6_rdv%0d", i), 32'(ic.s_readdatavalid), 32'd0);
      check($sformatf("t6_rdata%0d", i), ic.s_readdata, 32'h0);
      @(negedge clk);
    end
    check("t6_reg0_post", reg_of(rq_c, 0), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
